bitmap_scan: RTL

- Downstream consumer of the 256-entry 1-bit array table.
- On a start pulse it snapshots the whole bitmap, then walks it in 8-bit chunks.
- It emits the index of every set bit, lowest first, on a valid/ready stream.
- It ends with a one-cycle done pulse and the total count of set bits found. The stream feeds the index-driven write/free logic that follows.

---
 rtl/bitmap_scan_pkg.sv | 16 +
 rtl/bitmap_scan_if.sv | 13 +
 rtl/bitmap_scan_penc.sv | 20 ++
 rtl/bitmap_scan.sv | 111 +++++++++++
 4 files changed

// File: rtl/bitmap_scan_pkg.sv
// rtl/bitmap_scan_pkg.sv - shared types and sizing for the bitmap scanner
package bitmap_scan_pkg;

  localparam int DEF_DEPTH   = 256;
  localparam int DEF_CHUNK_W = 8;
  localparam int NUM_CHUNKS  = DEF_DEPTH / DEF_CHUNK_W;
  localparam int PTR_W       = $clog2(NUM_CHUNKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/bitmap_scan_if.sv
// rtl/bitmap_scan_if.sv - index stream between scanner and write/free logic
interface bitmap_scan_if #(
  parameter int IDX_W = 8
);

  logic             idx_valid_o;
  logic             idx_ready_i;
  logic [IDX_W-1:0] idx_o;

  modport master (output idx_valid_o, output idx_o, input idx_ready_i);
  modport slave  (input idx_valid_o, input idx_o, output idx_ready_i);

endinterface

// File: rtl/bitmap_scan_penc.sv
// rtl/bitmap_scan_penc.sv - lowest-set-bit priority encoder for one chunk
module bitmap_penc #(
  parameter int CHUNK_W = 8,
  parameter int POS_W   = $clog2(CHUNK_W)
) (
  input  logic [CHUNK_W-1:0] chunk_i,
  output logic               any_o,
  output logic [POS_W-1:0]   pos_o
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    any_o = |chunk_i;
    pos_o = '0;
    for (int i = CHUNK_W - 1; i >= 0; i--) begin
      if (chunk_i[i]) pos_o = POS_W'(i);
    end
  end

endmodule

// File: rtl/bitmap_scan.sv
// rtl/bitmap_scan.sv - snapshots a bitmap and streams out set-bit indices
module bitmap_scan
  import bitmap_scan_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CHUNK_W = DEF_CHUNK_W,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic [DEPTH-1:0]   bitmap_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [IDX_W:0]     count_o,
  bitmap_scan_if.master      idx_s
);

  localparam int CHUNKS   = DEPTH / CHUNK_W;
  localparam int PTR_BITS = $clog2(CHUNKS);
  localparam int POS_BITS = $clog2(CHUNK_W);

  state_t                state_q, state_d;
  logic [DEPTH-1:0]      snap_q;
  logic [PTR_BITS-1:0]   ptr_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  valid_q;
  logic [IDX_W:0]        count_q;

  logic [CHUNK_W-1:0]    chunk;
  logic                  chunk_any;
  logic [POS_BITS-1:0]   chunk_pos;
  logic                  last_chunk;
  logic                  handshake;

  assign chunk      = snap_q[ptr_q*CHUNK_W +: CHUNK_W];
  assign last_chunk = (ptr_q == PTR_BITS'(CHUNKS - 1));
  assign handshake  = (state_q == EMIT) && valid_q && idx_s.idx_ready_i;

  bitmap_penc #(
    .CHUNK_W (CHUNK_W),
    .POS_W   (POS_BITS)
  ) u_penc (
    .chunk_i (chunk),
    .any_o   (chunk_any),
    .pos_o   (chunk_pos)
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SCAN;
      SCAN: begin
        if (chunk_any)       state_d = EMIT;
        else if (last_chunk) state_d = DONE;
      end
      EMIT:    if (handshake) state_d = SCAN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // After a handshake the emitted bit is cleared and the same chunk is re-encoded.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      snap_q  <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            snap_q  <= bitmap_i;
            ptr_q   <= '0;
            count_q <= '0;
          end
        end
        SCAN: begin
          if (chunk_any) begin
            idx_q   <= {ptr_q, chunk_pos};
            valid_q <= 1'b1;
          end else if (!last_chunk) begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        EMIT: begin
          if (handshake) begin
            snap_q[idx_q] <= 1'b0;
            count_q       <= count_q + 1'b1;
            valid_q       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o            = (state_q != IDLE);
  assign done_o            = (state_q == DONE);
  assign count_o           = count_q;
  assign idx_s.idx_valid_o = valid_q;
  assign idx_s.idx_o       = idx_q;

endmodule
